iiitb_univ_shreg: RTL and testbench

Parametrised successor to the 4-bit PIPO register. It is a WIDTH-bit universal register with hold, parallel load, logical shift and rotate in both directions, and serial in/out at both ends. A burst engine shifts by a programmable count, one bit per cycle, and reports busy/done. It is used as the team's generic load/shift/serialise stage.

---
 rtl/iiitb_shreg_pkg.sv | 46 ++++
 rtl/iiitb_shreg_burst_ctl.sv | 68 ++++++
 rtl/iiitb_univ_shreg.sv | 120 ++++++++++++
 tb/tb_iiitb_univ_shreg.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/iiitb_shreg_pkg.sv
// Shared types and the shift helper for the iiitb universal shift register.
// Optional parity output on the top is enabled with IIITB_SHREG_PARITY_EN.
package iiitb_shreg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD    = 3'd0,
        MODE_LOAD    = 3'd1,
        MODE_SHL     = 3'd2,
        MODE_SHR     = 3'd3,
        MODE_ROL     = 3'd4,
        MODE_ROR     = 3'd5,
        MODE_BURST_L = 3'd6,
        MODE_BURST_R = 3'd7
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // The helper works on a fixed-size container; WIDTH must not exceed SHREG_MAX_W.
    localparam int SHREG_MAX_W = 64;
    localparam int SHREG_IDX_W = 6;

    // One-bit shift of value[msb:0]; bits above msb in the result are don't-care.
    function automatic logic [SHREG_MAX_W-1:0] shreg_shift(
        input logic [SHREG_MAX_W-1:0] value,
        input logic [SHREG_IDX_W-1:0] msb,
        input logic                   left,
        input logic                   rotate,
        input logic                   fill
    );
        logic [SHREG_MAX_W-1:0] res;
        logic                   end_bit;
        end_bit = rotate ? (left ? value[msb] : value[0]) : fill;
        if (left) begin
            res    = {value[SHREG_MAX_W-2:0], 1'b0};
            res[0] = end_bit;
        end else begin
            res      = {1'b0, value[SHREG_MAX_W-1:1]};
            res[msb] = end_bit;
        end
        return res;
    endfunction

endpackage

// File: rtl/iiitb_shreg_burst_ctl.sv
// Burst sequencer: clamps the shift count, runs one shift per cycle, and
// generates busy/done plus the shift strobe and direction for the datapath.
module iiitb_shreg_burst_ctl
    import iiitb_shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          en,
    input  mode_e         mode,
    input  logic [CW-1:0] shamt,
    output logic          shift_en,
    output logic          shift_left,
    output logic          busy,
    output logic          done,
    output state_e        state
);

    logic [CW-1:0] n;
    logic [CW-1:0] rem;
    logic          dir_q;
    logic          start;

    always_comb begin
        n          = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;
        start      = en && (state == ST_IDLE) &&
                     ((mode == MODE_BURST_L) || (mode == MODE_BURST_R));
        // The accepting edge already performs the first shift.
        shift_en   = (state == ST_BURST) || (start && (n != '0));
        shift_left = (state == ST_BURST) ? dir_q : (mode == MODE_BURST_L);
    end

    assign busy = (state == ST_BURST);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
            rem   <= '0;
            dir_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dir_q <= (mode == MODE_BURST_L);
                        if (n > CW'(1)) begin
                            state <= ST_BURST;
                            rem   <= n - CW'(1);
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    rem <= rem - CW'(1);
                    if (rem == CW'(1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/iiitb_univ_shreg.sv
// WIDTH-bit universal register: hold, load, shift/rotate both ways, serial I/O, bursts.
// Define IIITB_SHREG_PARITY_EN to add the registered even-parity output.
module iiitb_univ_shreg
    import iiitb_shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pi,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [CW-1:0]    shamt,
    output logic [WIDTH-1:0] po,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
`ifdef IIITB_SHREG_PARITY_EN
    ,
    output logic             parity
`endif
);

    // Command handshake: en is a strobe qualified by busy. A command is taken on
    // the rising edge where en=1 and busy=0; while busy=1 all command inputs are
    // ignored. done pulses for one cycle after the last burst shift, and a new
    // command may be presented in that same cycle.

    localparam logic [SHREG_IDX_W-1:0] MSB = SHREG_IDX_W'(WIDTH - 1);

    mode_e                  cmd;
    state_e                 state;
    logic                   shift_en;
    logic                   shift_left;
    logic                   accept;
    logic                   do_sh;
    logic                   sh_dir;
    logic                   sh_rot;
    logic                   sh_fill;
    logic [SHREG_MAX_W-1:0] po_ext;
    logic [SHREG_MAX_W-1:0] sh_res;
    logic [WIDTH-1:0]       po_nxt;
    logic                   unused_hi;

    assign cmd    = mode_e'(mode);
    assign accept = en && (state == ST_IDLE);

    iiitb_shreg_burst_ctl #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_ctl (
        .clk        (clk),
        .clear      (clear),
        .en         (en),
        .mode       (cmd),
        .shamt      (shamt),
        .shift_en   (shift_en),
        .shift_left (shift_left),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    always_comb begin
        do_sh   = 1'b0;
        sh_dir  = 1'b0;
        sh_rot  = 1'b0;
        sh_fill = 1'b0;
        if (shift_en) begin
            do_sh   = 1'b1;
            sh_dir  = shift_left;
            sh_fill = shift_left ? sin_r : sin_l;
        end else if (accept) begin
            case (cmd)
                MODE_SHL: begin do_sh = 1'b1; sh_dir = 1'b1; sh_fill = sin_r; end
                MODE_SHR: begin do_sh = 1'b1; sh_fill = sin_l; end
                MODE_ROL: begin do_sh = 1'b1; sh_dir = 1'b1; sh_rot = 1'b1; end
                MODE_ROR: begin do_sh = 1'b1; sh_rot = 1'b1; end
                default: ;
            endcase
        end

        po_ext             = '0;
        po_ext[WIDTH-1:0]  = po;
        sh_res             = shreg_shift(po_ext, MSB, sh_dir, sh_rot, sh_fill);

        po_nxt = po;
        if (do_sh)
            po_nxt = sh_res[WIDTH-1:0];
        else if (accept && (cmd == MODE_LOAD))
            po_nxt = pi;
    end

    // Bits of the helper's container above MSB carry no information.
    assign unused_hi = ^sh_res;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            po <= '0;
        else
            po <= po_nxt;
    end

    assign sout_l = po[WIDTH-1];
    assign sout_r = po[0];

`ifdef IIITB_SHREG_PARITY_EN
    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            parity <= 1'b0;
        else
            parity <= ^po_nxt;
    end
`endif

endmodule

// File: tb/tb_iiitb_univ_shreg.sv
// Directed bench for iiitb_univ_shreg (WIDTH=8): a driver pushes hand-computed
// post-edge expectations into exp_q and a monitor pops and compares them.
module tb_iiitb_univ_shreg;
    import iiitb_shreg_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          clear;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [W-1:0]  pi = '0;
    logic          sin_l = 1'b0;
    logic          sin_r = 1'b0;
    logic [CW-1:0] shamt = '0;
    logic [W-1:0]  po;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;
`ifdef IIITB_SHREG_PARITY_EN
    logic          parity;
`endif

    int checks = 0;
    int errors = 0;

    // {po, busy, done} expected after the next rising edge
    logic [W+1:0] exp_q[$];

    iiitb_univ_shreg #(.WIDTH(W)) dut (
        .clk    (clk),
        .clear  (clear),
        .en     (en),
        .mode   (mode),
        .pi     (pi),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .shamt  (shamt),
        .po     (po),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
`ifdef IIITB_SHREG_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- check helpers ----------------
    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] p,
                        input logic sl, input logic sr, input logic [CW-1:0] sh,
                        input logic [7:0] ep, input logic eb, input logic ed);
        @(negedge clk);
        en    = e;
        mode  = m;
        pi    = p;
        sin_l = sl;
        sin_r = sr;
        shamt = sh;
        exp_q.push_back({ep, eb, ed});
        @(posedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always begin
        logic [W+1:0] e;
        logic [W-1:0] ep;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ep = e[W+1:2];
            chk8("po", po, ep);
            chk1("sout_l", sout_l, ep[W-1]);
            chk1("sout_r", sout_r, ep[0]);
            chk1("busy", busy, e[1]);
            chk1("done", done, e[0]);
`ifdef IIITB_SHREG_PARITY_EN
            chk1("parity", parity, ^ep);
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clear = 1'b0;
        #1;
        chk8("rst_po", po, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;

        // load and logical shifts
        step(1, MODE_LOAD, 8'h96, 0, 0, 0, 8'h96, 0, 0);
        step(1, MODE_SHL,  8'h00, 0, 1, 0, 8'h2D, 0, 0);
        step(1, MODE_SHR,  8'h00, 0, 0, 0, 8'h16, 0, 0);

        // rotates, hold and idle
        step(1, MODE_LOAD, 8'h81, 0, 0, 0, 8'h81, 0, 0);
        step(1, MODE_ROL,  8'h00, 1, 0, 0, 8'h03, 0, 0);
        step(1, MODE_ROR,  8'h00, 0, 1, 0, 8'h81, 0, 0);
        step(1, MODE_ROR,  8'h00, 0, 1, 0, 8'hC0, 0, 0);
        step(1, MODE_HOLD, 8'hFF, 1, 1, 0, 8'hC0, 0, 0);
        step(0, MODE_LOAD, 8'hFF, 1, 1, 0, 8'hC0, 0, 0);
        step(0, MODE_SHL,  8'hFF, 1, 1, 0, 8'hC0, 0, 0);

        // burst right by 3; commands during busy are ignored
        step(1, MODE_LOAD,    8'hF0, 0, 0, 0, 8'hF0, 0, 0);
        step(1, MODE_BURST_R, 8'h00, 0, 0, 3, 8'h78, 1, 0);
        step(1, MODE_LOAD,    8'hAA, 0, 1, 5, 8'h3C, 1, 0);
        step(1, MODE_SHL,     8'hAA, 0, 1, 5, 8'h1E, 0, 1);
        step(1, MODE_HOLD,    8'h00, 0, 0, 0, 8'h1E, 0, 0);

        // zero-length burst: no shift, no busy, done pulse
        step(1, MODE_BURST_L, 8'h00, 1, 1, 0, 8'h1E, 0, 1);
        step(1, MODE_HOLD,    8'h00, 0, 0, 0, 8'h1E, 0, 0);

        // over-range count clamps to 8; fill with ones from the LSB
        step(1, MODE_LOAD,    8'h00, 0, 0, 0, 8'h00, 0, 0);
        step(1, MODE_BURST_L, 8'h00, 0, 1, 15, 8'h01, 1, 0);
        for (int k = 2; k <= 8; k++) begin
            logic [8:0] v;
            v = (9'd1 << k) - 9'd1;
            step(0, MODE_HOLD, 8'h00, 0, 1, 0, v[7:0], (k < 8), (k == 8));
        end
        // LOAD presented in the done cycle is accepted
        step(1, MODE_LOAD,    8'h5A, 0, 0, 0, 8'h5A, 0, 0);

        // single-bit burst: one shift, no busy
        step(1, MODE_BURST_R, 8'h00, 1, 0, 1, 8'hAD, 0, 1);
        step(1, MODE_HOLD,    8'h00, 0, 0, 0, 8'hAD, 0, 0);

        // asynchronous reset in the third cycle of an 8-bit burst
        step(1, MODE_LOAD,    8'hFF, 0, 0, 0, 8'hFF, 0, 0);
        step(1, MODE_BURST_R, 8'h00, 0, 0, 8, 8'h7F, 1, 0);
        step(0, MODE_HOLD,    8'h00, 0, 0, 0, 8'h3F, 1, 0);
        #3;
        clear = 1'b0;
        #1;
        chk8("mid_rst_po", po, 8'h00);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        step(0, MODE_HOLD,    8'h00, 0, 0, 0, 8'h00, 0, 0);
        @(negedge clk);
        clear = 1'b1;
        step(0, MODE_HOLD,    8'h00, 0, 0, 0, 8'h00, 0, 0);
        step(1, MODE_LOAD,    8'h5A, 0, 0, 0, 8'h5A, 0, 0);

        // parity patterns (parity itself is checked when enabled)
        step(1, MODE_LOAD,    8'h07, 0, 0, 0, 8'h07, 0, 0);
        step(1, MODE_LOAD,    8'h0F, 0, 0, 0, 8'h0F, 0, 0);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got no end of stimulus expected end before 100000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
